// File: rtl/regfile_pkg.sv
// Shared constants, index type and write-port arbitration for the multi-ported register file.
package regfile_pkg;

   localparam int RF_DATA_WIDTH = 32;
   localparam int RF_NUM_REG    = 32;
   localparam int RF_MAX_PORTS  = 16;

   typedef logic [$clog2(RF_NUM_REG)-1:0] reg_idx_t;

   // Highest set bit wins; storage and bypass must agree on the same port.
   function automatic int win_port(input logic [RF_MAX_PORTS-1:0] hit);
      int w;
      w = 0;
      for (int p = 0; p < RF_MAX_PORTS; p++) begin
         if (hit[p]) w = p;
      end
      return w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Write-after-write scoreboard: one busy bit per register, set on reservation, cleared by writeback.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REG  = RF_NUM_REG,
   parameter bit ZERO_REG = 1'b1,
   localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REG-1:0]      wr_clr,
   input  logic                    rsv_en,
   input  logic [SELECT_WIDTH-1:0] rsv_sel,
   output logic [NUM_REG-1:0]      busy,
   output logic [NUM_REG-1:0]      eff_busy,
   output logic                    rsv_conflict
);

   logic               rsv_in_range;
   logic               rsv_set;
   logic [NUM_REG-1:0] busy_next;

   assign eff_busy = busy & ~wr_clr;

   // A write landing in the same cycle frees the slot, so the reservation becomes the new producer.
   always_comb begin
      rsv_in_range = int'(rsv_sel) < NUM_REG;
      rsv_conflict = 1'b0;
      if (rsv_en && rsv_in_range) rsv_conflict = eff_busy[rsv_sel];
      rsv_set   = rsv_en && !rsv_conflict && rsv_in_range && !(ZERO_REG && rsv_sel == '0);
      busy_next = eff_busy;
      if (rsv_set) busy_next[rsv_sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_next;
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with highest-port-wins write arbitration, optional bypass and zero register.
module register_file_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int NUM_REG    = RF_NUM_REG,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1,
   localparam int SELECT_WIDTH = $clog2(NUM_REG)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_WR-1:0]                    i_wr_en,
   input  logic [NUM_WR-1:0][SELECT_WIDTH-1:0]  i_wr_sel,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    i_wr_data,
   input  logic [NUM_RD-1:0][SELECT_WIDTH-1:0]  i_rd_sel,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    o_rd_data,
   output logic [NUM_RD-1:0]                    o_rd_busy,
   input  logic                                 i_rsv_en,
   input  logic [SELECT_WIDTH-1:0]              i_rsv_sel,
   output logic                                 o_rsv_conflict
);

   logic [NUM_WR-1:0]                  wr_vld;
   logic [NUM_REG-1:0][NUM_WR-1:0]     wr_hit;
   logic [NUM_REG-1:0]                 wr_any;
   logic [NUM_REG-1:0][DATA_WIDTH-1:0] wr_val;
   logic [DATA_WIDTH-1:0]              regs [NUM_REG];
   logic [NUM_REG-1:0]                 busy;
   logic [NUM_REG-1:0]                 eff_busy;
   int                                 win;

   function automatic logic in_range(input logic [SELECT_WIDTH-1:0] sel);
      return int'(sel) < NUM_REG;
   endfunction

   function automatic logic is_zero(input logic [SELECT_WIDTH-1:0] sel);
      return ZERO_REG && sel == '0;
   endfunction

   always_comb begin
      win = 0;
      for (int p = 0; p < NUM_WR; p++) begin
         wr_vld[p] = i_wr_en[p] && in_range(i_wr_sel[p]) && !is_zero(i_wr_sel[p]);
      end
      for (int i = 0; i < NUM_REG; i++) begin
         for (int p = 0; p < NUM_WR; p++) begin
            wr_hit[i][p] = wr_vld[p] && (int'(i_wr_sel[p]) == i);
         end
         wr_any[i] = |wr_hit[i];
         win       = win_port(RF_MAX_PORTS'(wr_hit[i]));
         wr_val[i] = '0;
         for (int p = 0; p < NUM_WR; p++) begin
            if (p == win) wr_val[i] = i_wr_data[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REG; i++) begin
            if (wr_any[i]) regs[i] <= wr_val[i];
         end
      end
   end

   rf_scoreboard #(
      .NUM_REG  (NUM_REG),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_clr       (wr_any),
      .rsv_en       (i_rsv_en),
      .rsv_sel      (i_rsv_sel),
      .busy         (busy),
      .eff_busy     (eff_busy),
      .rsv_conflict (o_rsv_conflict)
   );

   // Bypass is gated by rst_n so reads stay zero while reset is held.
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         o_rd_data[r] = '0;
         o_rd_busy[r] = 1'b0;
         if (in_range(i_rd_sel[r]) && !is_zero(i_rd_sel[r])) begin
            if (BYPASS && rst_n && wr_any[i_rd_sel[r]]) o_rd_data[r] = wr_val[i_rd_sel[r]];
            else                                        o_rd_data[r] = regs[i_rd_sel[r]];
            o_rd_busy[r] = BYPASS ? eff_busy[i_rd_sel[r]] : busy[i_rd_sel[r]];
         end
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: bypass and non-bypass instances share stimulus, checked via a queue.
module tb_register_file_mp;

   localparam int DW = 32;
   localparam int SW = 5;

   typedef enum int {K_RD0, K_RD1, K_BZ0, K_BZ1, K_CF, K_NRD0, K_NRD1, K_NBZ0} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic                  clk;
   logic                  rst_n;
   logic [1:0]            wr_en;
   logic [1:0][SW-1:0]    wr_sel;
   logic [1:0][DW-1:0]    wr_data;
   logic [1:0][SW-1:0]    rd_sel;
   logic                  rsv_en;
   logic [SW-1:0]         rsv_sel;
   logic [1:0][DW-1:0]    rd_data, nb_rd_data;
   logic [1:0]            rd_busy, nb_rd_busy;
   logic                  rsv_conflict, nb_rsv_conflict;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   register_file_mp dut (
      .clk(clk), .rst_n(rst_n),
      .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
      .i_rd_sel(rd_sel), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
      .i_rsv_en(rsv_en), .i_rsv_sel(rsv_sel), .o_rsv_conflict(rsv_conflict)
   );

   register_file_mp #(.BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n),
      .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
      .i_rd_sel(rd_sel), .o_rd_data(nb_rd_data), .o_rd_busy(nb_rd_busy),
      .i_rsv_en(rsv_en), .i_rsv_sel(rsv_sel), .o_rsv_conflict(nb_rsv_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic expect_val(input kind_t k, input logic [31:0] v, input string t);
      exp_t e;
      e.kind = k;
      e.val  = v;
      e.tag  = t;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_RD0:   obs = rd_data[0];
            K_RD1:   obs = rd_data[1];
            K_BZ0:   obs = 32'(rd_busy[0]);
            K_BZ1:   obs = 32'(rd_busy[1]);
            K_CF:    obs = 32'(rsv_conflict);
            K_NRD0:  obs = nb_rd_data[0];
            K_NRD1:  obs = nb_rd_data[1];
            default: obs = 32'(nb_rd_busy[0]);
         endcase
         vectors++;
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   task automatic write(input int p, input logic [SW-1:0] s, input logic [DW-1:0] d);
      wr_en[p]   = 1'b1;
      wr_sel[p]  = s;
      wr_data[p] = d;
   endtask

   task automatic reserve(input logic [SW-1:0] s);
      rsv_en  = 1'b1;
      rsv_sel = s;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = '0; wr_sel = '0; wr_data = '0;
      rd_sel = '0; rsv_en = 1'b1; rsv_sel = 5'd3;

      // reset state
      rd_sel[0] = 5'd5; rd_sel[1] = 5'd6;
      expect_val(K_RD0, 32'h0, "reset_rd0");
      expect_val(K_BZ0, 32'h0, "reset_busy0");
      expect_val(K_CF,  32'h0, "reset_conflict");
      check();
      @(negedge clk); idle(); rst_n = 1'b1;

      // write r5, bypass read on port 0
      @(negedge clk); idle();
      write(0, 5'd5, 32'hDEADBEEF); rd_sel[0] = 5'd5; rd_sel[1] = 5'd6;
      expect_val(K_RD0,  32'hDEADBEEF, "r5_bypass");
      expect_val(K_NRD0, 32'h0,        "r5_nobypass_old");
      expect_val(K_RD1,  32'h0,        "r6_zero");
      check();

      @(negedge clk); idle();
      rd_sel[0] = 5'd6; rd_sel[1] = 5'd5;
      expect_val(K_RD1,  32'hDEADBEEF, "r5_stored");
      expect_val(K_NRD1, 32'hDEADBEEF, "r5_stored_nb");
      expect_val(K_RD0,  32'h0,        "r6_stored");
      check();

      // same-cycle collision on r3
      @(negedge clk); idle();
      write(0, 5'd3, 32'h11); write(1, 5'd3, 32'h22); rd_sel[0] = 5'd3;
      expect_val(K_RD0,  32'h22, "r3_collide_bypass");
      expect_val(K_NRD0, 32'h0,  "r3_collide_nb_old");
      check();

      @(negedge clk); idle();
      rd_sel[0] = 5'd3;
      expect_val(K_RD0,  32'h22, "r3_collide_stored");
      expect_val(K_NRD0, 32'h22, "r3_collide_stored_nb");
      check();

      // disabled high port does not win
      @(negedge clk); idle();
      write(0, 5'd3, 32'h33); write(1, 5'd3, 32'h44); wr_en[1] = 1'b0; rd_sel[1] = 5'd3;
      expect_val(K_RD1, 32'h33, "r3_port1_disabled");
      check();

      // r7 bypass vs non-bypass
      @(negedge clk); idle();
      write(1, 5'd7, 32'hA5); rd_sel[1] = 5'd7;
      expect_val(K_RD1,  32'hA5, "r7_bypass");
      expect_val(K_NRD1, 32'h0,  "r7_nobypass_old");
      check();

      // zero register
      @(negedge clk); idle();
      write(0, 5'd0, 32'hFFFF); rd_sel[0] = 5'd0;
      expect_val(K_RD0, 32'h0, "r0_write_same_cycle");
      check();

      @(negedge clk); idle();
      reserve(5'd0); rd_sel[0] = 5'd0;
      expect_val(K_RD0,  32'h0, "r0_read");
      expect_val(K_NRD0, 32'h0, "r0_read_nb");
      expect_val(K_BZ0,  32'h0, "r0_busy");
      expect_val(K_CF,   32'h0, "r0_reserve_conflict");
      check();

      // reserve r9; r0 still never busy
      @(negedge clk); idle();
      reserve(5'd9); rd_sel[0] = 5'd9; rd_sel[1] = 5'd0;
      expect_val(K_CF,  32'h0, "r9_reserve_conflict");
      expect_val(K_BZ0, 32'h0, "r9_busy_before_edge");
      expect_val(K_BZ1, 32'h0, "r0_busy_after_reserve");
      check();

      @(negedge clk); idle();
      reserve(5'd9); rd_sel[0] = 5'd9;
      expect_val(K_BZ0, 32'h1, "r9_busy");
      expect_val(K_CF,  32'h1, "r9_waw_conflict");
      check();

      @(negedge clk); idle();
      write(0, 5'd9, 32'h99); reserve(5'd9); rd_sel[0] = 5'd9;
      expect_val(K_CF,   32'h0,  "r9_write_and_reserve_conflict");
      expect_val(K_BZ0,  32'h0,  "r9_eff_busy_bypass");
      expect_val(K_NBZ0, 32'h1,  "r9_busy_nobypass");
      expect_val(K_RD0,  32'h99, "r9_data_bypass");
      check();

      @(negedge clk); idle();
      rd_sel[0] = 5'd9;
      expect_val(K_BZ0,  32'h1,  "r9_new_producer");
      expect_val(K_NBZ0, 32'h1,  "r9_new_producer_nb");
      expect_val(K_NRD0, 32'h99, "r9_stored_nb");
      check();

      @(negedge clk); idle();
      write(1, 5'd9, 32'h9A); rd_sel[0] = 5'd9;
      expect_val(K_BZ0,  32'h0, "r9_clear_bypass");
      expect_val(K_NBZ0, 32'h1, "r9_clear_nb_pending");
      check();

      @(negedge clk); idle();
      rd_sel[0] = 5'd9;
      expect_val(K_BZ0,  32'h0,  "r9_cleared");
      expect_val(K_NBZ0, 32'h0,  "r9_cleared_nb");
      expect_val(K_RD0,  32'h9A, "r9_final_data");
      check();

      // reserve r4, then asynchronous reset mid-cycle
      @(negedge clk); idle();
      reserve(5'd4);
      expect_val(K_CF, 32'h0, "r4_reserve_conflict");
      check();

      @(negedge clk); idle();
      reserve(5'd4); rd_sel[0] = 5'd9; rd_sel[1] = 5'd4;
      expect_val(K_BZ1, 32'h1, "r4_busy");
      expect_val(K_CF,  32'h1, "r4_conflict");
      check();

      @(posedge clk); #2;
      rst_n = 1'b0;
      expect_val(K_RD0,  32'h0, "async_reset_r9_data");
      expect_val(K_NRD0, 32'h0, "async_reset_r9_data_nb");
      expect_val(K_BZ1,  32'h0, "async_reset_r4_busy");
      expect_val(K_CF,   32'h0, "async_reset_conflict");
      check();

      @(negedge clk); idle(); rst_n = 1'b1;
      rd_sel[0] = 5'd5; rd_sel[1] = 5'd4;
      expect_val(K_RD0, 32'h0, "post_reset_r5");
      expect_val(K_BZ1, 32'h0, "post_reset_r4_busy");
      check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-ported, parametrised general-purpose register file with an integrated write-after-write scoreboard. It replaces the single-write, flat-output register bank in the core datapath. It serves NUM_RD decode-stage read ports and NUM_WR writeback ports, with optional same-cycle write-to-read bypass and an optional hardwired-zero register 0. The scoreboard tracks registers with a pending producer so decode can stall on busy operands.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REG, 32, number of architectural registers (≥2)
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, and is never busy
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads
- SELECT_WIDTH, localparam $clog2(NUM_REG)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- i_wr_en  in  [NUM_WR]  per-port write enable
- i_wr_sel  in  [NUM_WR][SELECT_WIDTH]  write index
- i_wr_data  in  [NUM_WR][DATA_WIDTH]  write data
- i_rd_sel  in  [NUM_RD][SELECT_WIDTH]  read index
- o_rd_data  out  [NUM_RD][DATA_WIDTH]  read data, combinational
- o_rd_busy  out  [NUM_RD]  operand has a pending producer
- i_rsv_en  in  1  reserve a destination (instruction issue)
- i_rsv_sel  in  [SELECT_WIDTH]  reserved index
- o_rsv_conflict  out  1  reservation refused (WAW); caller must stall and retry

## Operation
- Storage: NUM_REG × DATA_WIDTH flops, plus a busy bit per register.
- Write valid: i_wr_en[p] && i_wr_sel[p] < NUM_REG && !(ZERO_REG && i_wr_sel[p]==0). Invalid writes are dropped silently.
- Write collision: when several valid writes target the same index in one cycle, the highest port index wins.
- Read:
  - o_rd_data[r] is 0 if the index ≥ NUM_REG, or if ZERO_REG and the index is 0.
  - Otherwise, with BYPASS=1 and a valid write this cycle to the same index, it returns the winning write data.
  - Otherwise it returns stored data.
- Busy clear: any valid write to index i clears busy[i] at the next edge.
- Effective busy: eff_busy[i] = busy[i] && !(valid write to i this cycle).
- Read busy:
  - BYPASS=1: o_rd_busy[r] = eff_busy[sel].
  - BYPASS=0: o_rd_busy[r] = busy[sel].
  - Out-of-range index or zero register: 0.
- Reservation:
  - o_rsv_conflict = i_rsv_en && eff_busy[i_rsv_sel].
  - If there is no conflict and the index is valid, busy[i_rsv_sel] is set at the edge.
  - A reservation to the zero register or an out-of-range index is accepted and records nothing.
- Simultaneous reserve and write to the same index: the write clears, the reservation sets, so busy=1 after the edge. This is a new producer, and o_rsv_conflict=0.

## Timing
- Read latency 0 (combinational from i_rd_sel and register state).
- Write visibility:
  - BYPASS=1: visible on reads in the same cycle.
  - BYPASS=0: visible from the cycle after the edge.
- Busy set by reservation: visible from the cycle after the edge.
- o_rsv_conflict: combinational, same cycle.
- Reset: rst_n low asynchronously clears all registers to 0 and all busy bits to 0. While rst_n is low, o_rd_data=0, o_rd_busy=0 and o_rsv_conflict=0. Writes and reservations are ignored until the first edge after release.
- Reset mid-operation: pending reservations are lost. Upstream flush is the caller's responsibility.

## Structure
- Package regfile_pkg holds:
  - default constants (RF_DATA_WIDTH=32, RF_NUM_REG=32)
  - the reg_idx_t typedef
  - a function for winning-write-port selection, shared by storage and bypass
- Sub-module rf_scoreboard holds:
  - the busy vector and reservation/clear logic
  - the eff_busy and conflict outputs
- The parent module holds storage, write arbitration and read muxing.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port 0. Next cycle, read r5 on port 1 → 0xDEADBEEF. Read r6 → 0.
- Same cycle: port 0 writes r3=0x11 and port 1 writes r3=0x22. Following cycle, read r3 → 0x22.
- BYPASS=1: write r7=0xA5 while reading r7 in the same cycle → 0xA5; BYPASS=0 → the old value 0.
- ZERO_REG=1: write r0=0xFFFF, then read r0 → 0, and busy=0. Reserve r0 → no conflict, r0 never busy.
- Scoreboard sequence:
  - Reserve r9, then read r9 → busy=1.
  - Reserve r9 again → o_rsv_conflict=1.
  - Write r9 while also reserving r9 → conflict=0, busy stays 1.
  - Write r9 again → busy=0.
- Reserve r4, then assert rst_n=0 mid-cycle → r4 busy=0 and all data 0 immediately, without a clock edge.
